// File: rtl/demux_router_if.sv
// rtl/demux_router_if.sv - stream-in / N-lane-out bundle for demux_router
interface demux_router_if #(
  parameter int WIDTH = 8,
  parameter int N     = 2
);
  localparam int SEL_W = $clog2(N);

  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   in_data;
  logic [SEL_W-1:0]   in_sel;
  logic               mode;
  logic [N-1:0]       out_valid;
  logic [N-1:0]       out_ready;
  logic [N*WIDTH-1:0] out_data;
  logic               sel_err;
  logic [SEL_W-1:0]   rr_ptr;

  modport master (
    output in_valid, in_data, in_sel, mode, out_ready,
    input  in_ready, out_valid, out_data, sel_err, rr_ptr
  );

  modport slave (
    input  in_valid, in_data, in_sel, mode, out_ready,
    output in_ready, out_valid, out_data, sel_err, rr_ptr
  );
endinterface

// File: rtl/demux_router.sv
// rtl/demux_router.sv - registered 1-to-N demux with one-entry lane holding registers
module demux_router #(
  parameter int WIDTH = 8,
  parameter int N     = 2
) (
  input  logic          clk,
  input  logic          reset,
  demux_router_if.slave bus
);
  localparam int SEL_W = $clog2(N);
  localparam int NP    = 1 << SEL_W;

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} lane_t;

  lane_t              state_q [N];
  lane_t              state_d [N];
  logic [N*WIDTH-1:0] data_q;
  logic [SEL_W-1:0]   rr_q;
  logic               err_q;

  logic [SEL_W-1:0]   tgt;
  logic               tgt_ok;
  logic               in_ready;
  logic               accept;
  logic               drop;
  logic [NP-1:0]      full_ext;
  logic [NP-1:0]      rdy_ext;
  logic [N-1:0]       load;
  logic [N-1:0]       valid_vec;

  // Padded views let an out-of-range in_sel index safely; padding reads as empty.
  always_comb begin
    full_ext  = '0;
    rdy_ext   = '0;
    valid_vec = '0;
    for (int i = 0; i < N; i++) begin
      full_ext[i]  = (state_q[i] == FULL);
      rdy_ext[i]   = bus.out_ready[i];
      valid_vec[i] = (state_q[i] == FULL);
    end
  end

  always_comb begin
    tgt      = bus.mode ? rr_q : bus.in_sel;
    tgt_ok   = (int'(tgt) < N);
    in_ready = !tgt_ok || !full_ext[tgt] || rdy_ext[tgt];
    accept   = bus.in_valid && in_ready;
    drop     = bus.in_valid && !tgt_ok;
  end

  // Refill has priority over drain so a lane can pass one word per cycle.
  always_comb begin
    load = '0;
    for (int i = 0; i < N; i++) begin
      state_d[i] = state_q[i];
      load[i]    = accept && tgt_ok && (int'(tgt) == i);
      if (load[i])
        state_d[i] = FULL;
      else if (state_q[i] == FULL && bus.out_ready[i])
        state_d[i] = EMPTY;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N; i++)
        state_q[i] <= EMPTY;
      data_q <= '0;
      rr_q   <= '0;
      err_q  <= 1'b0;
    end else begin
      for (int i = 0; i < N; i++) begin
        state_q[i] <= state_d[i];
        if (load[i])
          data_q[i*WIDTH +: WIDTH] <= bus.in_data;
      end
      err_q <= drop;
      if (accept && bus.mode)
        rr_q <= (int'(rr_q) == N - 1) ? '0 : rr_q + 1'b1;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = valid_vec;
  assign bus.out_data  = data_q;
  assign bus.sel_err   = err_q;
  assign bus.rr_ptr    = rr_q;
endmodule

// File: doc/demux_router.md
# demux_router

Registered 1-to-N demultiplexer: the return path for the team's 2:1 line multiplexer, routing one input stream onto one of N output lanes. Each lane has a one-entry holding register with valid/ready handshake on both sides. The lane is chosen by an explicit select or by an internal round-robin pointer. It sits downstream of a muxed link and fans traffic back out to per-line consumers.

## Interface
- WIDTH, 8, data bits per transfer
- N, 2, number of output lanes (2..16)
- SEL_W, $clog2(N), select width (derived, not overridden)

- clk  in  1  single clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- in_valid  in  1  input transfer offered
- in_ready  out  1  block can accept this cycle
- in_data  in  WIDTH  input payload
- in_sel  in  SEL_W  target lane, used when mode=0
- mode  in  1  0 = explicit select, 1 = round-robin
- out_valid  out  N  bit i: lane i holds data
- out_ready  in  N  bit i: lane i consumer takes data
- out_data  out  N*WIDTH  lane i payload at bits [i*WIDTH +: WIDTH]
- sel_err  out  1  one-cycle pulse: out-of-range in_sel dropped
- rr_ptr  out  SEL_W  current round-robin target

## Operation
- Per-lane state: EMPTY or FULL, plus data register. Reset value: all EMPTY, out_valid=0, out_data=0, rr_ptr=0, sel_err=0.
- Target lane t: in_sel when mode=0, rr_ptr when mode=1. Sampled combinationally each cycle.
- in_ready = 1 when lane t is EMPTY, or FULL with out_ready[t]=1 (same-cycle drain and refill).
- mode=0 with in_sel >= N: in_ready=1, transfer accepted and discarded, sel_err=1 next cycle, no lane changes.
- Input accept (in_valid & in_ready, valid t): lane t becomes FULL with in_data.
- Output drain (out_valid[i] & out_ready[i]): lane i becomes EMPTY unless refilled the same edge. Refill wins.
- Lanes drain independently. Multiple lanes may drain on the same edge.
- rr_ptr advances by 1 only on an accepted transfer with mode=1. It wraps from N-1 to 0. It holds in mode=0 and while stalled.
- Switching mode does not reset rr_ptr.
- out_data[i] holds its value while lane i is FULL and not draining. Contents of an EMPTY lane are don't-care; implementation retains the last value.
- in_valid=0: no state changes other than drains.

## Timing
- Latency 1: a transfer accepted on edge k gives out_valid[t]=1 with the data from edge k onward.
- Throughput 1 transfer/cycle per lane when the consumer holds out_ready=1.
- in_ready is combinational from in_sel, mode, rr_ptr, lane state and out_ready[t]. No combinational path from in_data.
- out_valid, out_data, rr_ptr and sel_err are registered outputs.
- sel_err goes high for exactly the cycle after a dropped transfer. Back-to-back drops keep it high.
- Reset asserted mid-operation: all outputs return to reset values asynchronously and held data is lost. First accept is possible on the first edge after deassertion.
- Stall: in_valid=1 with in_ready=0. No change to lane t or rr_ptr. The upstream side must hold in_data and in_sel.

## Test plan
- Reset, N=2: mode=0, in_sel=0, in_data=0xA5, out_ready=2'b00. Next cycle out_valid=2'b01, out_data[7:0]=0xA5. Then in_sel=1, in_data=0x3C gives out_valid=2'b11, out_data[15:8]=0x3C.
- Backpressure: lane 0 FULL, out_ready[0]=0, in_sel=0 gives in_ready=0 and data is held. Raising out_ready[0]=1 with in_valid=1 and new data 0x11 makes in_ready=1. Lane 0 stays valid and shows 0x11 next cycle.
- Round-robin with N=4, mode=1, all out_ready=1: five transfers 0x01..0x05 land on lanes 0,1,2,3,0 in order, with rr_ptr sequence 0,1,2,3,0,1.
- Out-of-range with N=3, mode=0: in_sel=3 with in_valid=1 gives in_ready=1 and sel_err=1 for exactly one cycle. out_valid stays 3'b000.
- Reset mid-stream: with out_valid=2'b11 and rr_ptr=1, assert reset between edges. out_valid=0, rr_ptr=0 and sel_err=0 immediately. After deassertion, the first mode=1 transfer lands on lane 0.
- Mode switch: in mode=1 with rr_ptr=1, switch to mode=0 and send 2 transfers to lane 0. Back in mode=1, the next transfer goes to lane 1.
